// File: rtl/hazard_controller_rv_if.sv
// Hazard controller bundle: pipeline hazard inputs and the
// stall/flush/drain controls plus counters driven back to the pipeline.
interface hazard_controller_rv_if #(
    parameter int CNT_W = 16
);
    logic             ID_Ex_MemRead;
    logic [4:0]       ID_Ex_Rd;
    logic [4:0]       IF_Id_Rs1;
    logic [4:0]       IF_Id_Rs2;
    logic             IF_Id_UsesRs2;
    logic             branchTaken;
    logic             memBusy;
    logic             drainReq;
    logic             clearCounters;
    logic             PCWrite;
    logic             IF_IdWrite;
    logic             IF_IdFlush;
    logic             ID_ExBubble;
    logic             pipeHold;
    logic             drainAck;
    logic [CNT_W-1:0] stallCount;
    logic [CNT_W-1:0] flushCount;
    logic [1:0]       ctrlState;

    modport master (
        output ID_Ex_MemRead, ID_Ex_Rd, IF_Id_Rs1, IF_Id_Rs2,
        output IF_Id_UsesRs2, branchTaken, memBusy, drainReq,
        output clearCounters,
        input  PCWrite, IF_IdWrite, IF_IdFlush, ID_ExBubble,
        input  pipeHold, drainAck, stallCount, flushCount, ctrlState
    );

    modport slave (
        input  ID_Ex_MemRead, ID_Ex_Rd, IF_Id_Rs1, IF_Id_Rs2,
        input  IF_Id_UsesRs2, branchTaken, memBusy, drainReq,
        input  clearCounters,
        output PCWrite, IF_IdWrite, IF_IdFlush, ID_ExBubble,
        output pipeHold, drainAck, stallCount, flushCount, ctrlState
    );
endinterface

// File: rtl/hazard_controller_rv.sv
// RV pipeline hazard controller: load-use stall, branch flush, drain
// sequencing and memory freeze, with saturating stall/flush counters.
module hazard_controller_rv #(
    parameter int FLUSH_CYCLES = 1,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic                  clock,
    input  logic                  resetN,
    hazard_controller_rv_if.slave hz
);
    localparam int DW = $clog2(DRAIN_CYCLES + 1) + 1;
    localparam logic [1:0]    FL_RELOAD = 2'(FLUSH_CYCLES - 1);
    localparam logic [DW-1:0] DR_RELOAD = DW'(DRAIN_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        FLUSH = 2'b01,
        DRAIN = 2'b10
    } state_t;

    state_t           r_state;
    state_t           w_stateNxt;
    logic [1:0]       r_flushRem;
    logic [1:0]       w_flushRemNxt;
    logic [DW-1:0]    r_drainCnt;
    logic [DW-1:0]    w_drainCntNxt;
    logic [CNT_W-1:0] r_stallCnt;
    logic [CNT_W-1:0] r_flushCnt;

    logic w_loadUse;
    logic w_rs1Hit;
    logic w_rs2Hit;
    logic w_pcWrite;
    logic w_ifIdWrite;
    logic w_ifIdFlush;
    logic w_idExBubble;
    logic w_pipeHold;
    logic w_drainAck;

    assign w_rs1Hit  = (hz.ID_Ex_Rd == hz.IF_Id_Rs1);
    assign w_rs2Hit  = hz.IF_Id_UsesRs2 & (hz.ID_Ex_Rd == hz.IF_Id_Rs2);
    assign w_loadUse = hz.ID_Ex_MemRead & (hz.ID_Ex_Rd != 5'd0)
                     & (w_rs1Hit | w_rs2Hit);

    always_comb begin
        w_pcWrite     = 1'b1;
        w_ifIdWrite   = 1'b1;
        w_ifIdFlush   = 1'b0;
        w_idExBubble  = 1'b0;
        w_pipeHold    = 1'b0;
        w_drainAck    = 1'b0;
        w_stateNxt    = r_state;
        w_flushRemNxt = r_flushRem;
        w_drainCntNxt = r_drainCnt;

        if (!resetN) begin
            w_pcWrite    = 1'b0;
            w_ifIdWrite  = 1'b0;
            w_ifIdFlush  = 1'b1;
            w_idExBubble = 1'b1;
        end else if (hz.memBusy) begin
            // Full freeze: no sequencing state advances while memory stalls
            w_pcWrite   = 1'b0;
            w_ifIdWrite = 1'b0;
            w_pipeHold  = 1'b1;
        end else begin
            unique case (r_state)
                RUN: begin
                    if (hz.branchTaken) begin
                        w_ifIdFlush  = 1'b1;
                        w_idExBubble = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            w_stateNxt    = FLUSH;
                            w_flushRemNxt = FL_RELOAD;
                        end
                    end else if (hz.drainReq) begin
                        w_pcWrite     = 1'b0;
                        w_ifIdWrite   = 1'b0;
                        w_idExBubble  = 1'b1;
                        w_stateNxt    = DRAIN;
                        w_drainCntNxt = DR_RELOAD;
                    end else if (w_loadUse) begin
                        w_pcWrite    = 1'b0;
                        w_ifIdWrite  = 1'b0;
                        w_idExBubble = 1'b1;
                    end
                end
                FLUSH: begin
                    w_ifIdFlush  = 1'b1;
                    w_idExBubble = 1'b1;
                    if (hz.branchTaken) begin
                        w_flushRemNxt = FL_RELOAD;
                    end else if (r_flushRem <= 2'd1) begin
                        w_stateNxt    = RUN;
                        w_flushRemNxt = 2'd0;
                    end else begin
                        w_flushRemNxt = r_flushRem - 2'd1;
                    end
                end
                DRAIN: begin
                    w_idExBubble = 1'b1;
                    if (hz.branchTaken) begin
                        w_ifIdFlush   = 1'b1;
                        w_drainCntNxt = DR_RELOAD;
                    end else begin
                        w_pcWrite   = 1'b0;
                        w_ifIdWrite = 1'b0;
                        // Entry cycle counts as the first drain cycle
                        if (r_drainCnt <= DW'(2)) begin
                            w_drainAck    = 1'b1;
                            w_stateNxt    = RUN;
                            w_drainCntNxt = '0;
                        end else begin
                            w_drainCntNxt = r_drainCnt - DW'(1);
                        end
                    end
                end
                default: begin
                    w_stateNxt    = RUN;
                    w_flushRemNxt = 2'd0;
                    w_drainCntNxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!resetN) begin
            r_state    <= RUN;
            r_flushRem <= 2'd0;
            r_drainCnt <= '0;
        end else begin
            r_state    <= w_stateNxt;
            r_flushRem <= w_flushRemNxt;
            r_drainCnt <= w_drainCntNxt;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetN) begin
            r_stallCnt <= '0;
            r_flushCnt <= '0;
        end else if (hz.clearCounters) begin
            r_stallCnt <= '0;
            r_flushCnt <= '0;
        end else begin
            if (!w_pcWrite && (r_stallCnt != CNT_MAX)) begin
                r_stallCnt <= r_stallCnt + CNT_W'(1);
            end
            if (w_ifIdFlush && (r_flushCnt != CNT_MAX)) begin
                r_flushCnt <= r_flushCnt + CNT_W'(1);
            end
        end
    end

    assign hz.PCWrite     = w_pcWrite;
    assign hz.IF_IdWrite  = w_ifIdWrite;
    assign hz.IF_IdFlush  = w_ifIdFlush;
    assign hz.ID_ExBubble = w_idExBubble;
    assign hz.pipeHold    = w_pipeHold;
    assign hz.drainAck    = w_drainAck;
    assign hz.stallCount  = r_stallCnt;
    assign hz.flushCount  = r_flushCnt;
    assign hz.ctrlState   = r_state;
endmodule

// File: tb/tb_hazard_controller_rv.sv
// Directed-vector bench for hazard_controller_rv with a queue scoreboard
// checked once per cycle on the falling clock edge.
module tb_hazard_controller_rv;
    localparam logic [5:0] C_RUN = 6'b110000;
    localparam logic [5:0] C_RST = 6'b001100;
    localparam logic [5:0] C_STL = 6'b000100;
    localparam logic [5:0] C_FL  = 6'b111100;
    localparam logic [5:0] C_HLD = 6'b000010;
    localparam logic [5:0] C_ACK = 6'b000101;

    typedef struct {
        string       nm;
        logic [5:0]  ctl;
        logic [1:0]  st;
        logic [15:0] sc;
        logic [15:0] fc;
    } exp_t;

    logic clock;
    logic resetN;
    exp_t q[$];
    exp_t e;
    logic [5:0] act;
    int n_chk;
    int n_pass;

    hazard_controller_rv_if #(.CNT_W(16)) hz ();

    hazard_controller_rv #(
        .FLUSH_CYCLES(2),
        .DRAIN_CYCLES(3),
        .CNT_W(16)
    ) u_dut (
        .clock (clock),
        .resetN(resetN),
        .hz    (hz)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(negedge clock) begin
        if (q.size() > 0) begin
            e   = q.pop_front();
            act = {hz.PCWrite, hz.IF_IdWrite, hz.IF_IdFlush,
                   hz.ID_ExBubble, hz.pipeHold, hz.drainAck};
            n_chk = n_chk + 1;
            if (act === e.ctl && hz.ctrlState === e.st &&
                hz.stallCount === e.sc && hz.flushCount === e.fc) begin
                n_pass = n_pass + 1;
            end else begin
                $display("FAIL %s: got ctl=%b st=%0d sc=%0h fc=%0h, need ctl=%b st=%0d sc=%0h fc=%0h",
                         e.nm, act, hz.ctrlState, hz.stallCount, hz.flushCount,
                         e.ctl, e.st, e.sc, e.fc);
            end
        end
    end

    task automatic drive(input logic rn, mr, input logic [4:0] rd, rs1, rs2,
                         input logic u2, br, mb, dr, clr);
        resetN           = rn;
        hz.ID_Ex_MemRead = mr;
        hz.ID_Ex_Rd      = rd;
        hz.IF_Id_Rs1     = rs1;
        hz.IF_Id_Rs2     = rs2;
        hz.IF_Id_UsesRs2 = u2;
        hz.branchTaken   = br;
        hz.memBusy       = mb;
        hz.drainReq      = dr;
        hz.clearCounters = clr;
    endtask

    task automatic cyc(input string nm, input logic rn, mr,
                       input logic [4:0] rd, rs1, rs2,
                       input logic u2, br, mb, dr, clr,
                       input logic [5:0] ctl, input logic [1:0] st,
                       input logic [15:0] sc, fc);
        exp_t x;
        @(posedge clock);
        #1;
        drive(rn, mr, rd, rs1, rs2, u2, br, mb, dr, clr);
        x.nm  = nm;
        x.ctl = ctl;
        x.st  = st;
        x.sc  = sc;
        x.fc  = fc;
        q.push_back(x);
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        //   name           rn mr rd rs1 rs2 u2 br mb dr clr ctl  st sc fc
        cyc("reset",        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RST, 0, 0, 0);
        cyc("idle",         1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 0, 0, 0);
        cyc("lu_rs1",       1, 1, 5, 5, 0, 0, 0, 0, 0, 0, C_STL, 0, 0, 0);
        cyc("lu_done",      1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 0, 1, 0);
        cyc("lu_rd0",       1, 1, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 0, 1, 0);
        cyc("lu_rs2_nouse", 1, 1, 7, 3, 7, 0, 0, 0, 0, 0, C_RUN, 0, 1, 0);
        cyc("lu_rs2_use",   1, 1, 7, 3, 7, 1, 0, 0, 0, 0, C_STL, 0, 1, 0);
        cyc("no_load",      1, 0, 7, 3, 7, 1, 0, 0, 0, 0, C_RUN, 0, 2, 0);
        cyc("br",           1, 0, 0, 0, 0, 0, 1, 0, 0, 0, C_FL,  0, 2, 0);
        cyc("flush2",       1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_FL,  1, 2, 1);
        cyc("flush_end",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 0, 2, 2);
        cyc("br_b",         1, 0, 0, 0, 0, 0, 1, 0, 0, 0, C_FL,  0, 2, 2);
        cyc("flush_lu_ign", 1, 1, 5, 5, 0, 0, 0, 0, 0, 0, C_FL,  1, 2, 3);
        cyc("br_c",         1, 0, 0, 0, 0, 0, 1, 0, 0, 0, C_FL,  0, 2, 4);
        cyc("fl_busy1",     1, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_HLD, 1, 2, 5);
        cyc("fl_busy2",     1, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_HLD, 1, 3, 5);
        cyc("fl_busy3",     1, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_HLD, 1, 4, 5);
        cyc("fl_busy4",     1, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_HLD, 1, 5, 5);
        cyc("fl_resume",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_FL,  1, 6, 5);
        cyc("fl_run",       1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 0, 6, 6);
        cyc("drain1",       1, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_STL, 0, 6, 6);
        cyc("drain2",       1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_STL, 2, 7, 6);
        cyc("drain3_ack",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_ACK, 2, 8, 6);
        cyc("drain_run",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 0, 9, 6);
        cyc("dr_b1",        1, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_STL, 0, 9, 6);
        cyc("dr_lu_ign",    1, 1, 5, 5, 0, 0, 0, 0, 0, 0, C_STL, 2, 10, 6);
        cyc("dr_br",        1, 0, 0, 0, 0, 0, 1, 0, 0, 0, C_FL,  2, 11, 6);
        cyc("dr_reload1",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_STL, 2, 11, 7);
        cyc("dr_reload_ack",1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_ACK, 2, 12, 7);
        cyc("dr_c1",        1, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_STL, 0, 13, 7);
        cyc("rst_in_drain", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RST, 2, 14, 7);
        cyc("post_rst",     1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 0, 0, 0);
        cyc("prio_busy",    1, 1, 5, 5, 0, 0, 1, 1, 1, 0, C_HLD, 0, 0, 0);
        cyc("prio_br_dr",   1, 0, 0, 0, 0, 0, 1, 0, 1, 0, C_FL,  0, 1, 0);
        cyc("flush_dr_ign", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_FL,  1, 1, 1);
        cyc("idle_b",       1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 0, 1, 2);
        cyc("clr_over_inc", 1, 1, 5, 5, 0, 0, 0, 0, 0, 1, C_STL, 0, 1, 2);
        cyc("cleared",      1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 0, 0, 0);
        for (int i = 0; i < 65535; i++) begin
            @(posedge clock);
            #1;
            drive(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        end
        cyc("sat_hold",     1, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_HLD, 0, 16'hFFFF, 0);
        cyc("sat_idle",     1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 0, 16'hFFFF, 0);
        cyc("sat_clr",      1, 0, 0, 0, 0, 0, 0, 0, 0, 1, C_RUN, 0, 16'hFFFF, 0);
        cyc("sat_cleared",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 0, 0, 0);
        @(negedge clock);
        #1;
        n_chk = n_chk + 1;
        if (q.size() == 0) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL drain_queue: got %0d pending, need 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/hazard_controller_rv.md
HAZARD_CONTROLLER_RV -- requirements
Module: hazard_controller_rv

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 1, number of cycles IF_IdFlush/ID_ExBubble are held after a taken branch (1..3).
REQ-002 SHALL have parameter DRAIN_CYCLES, default 3, cycles to empty EX/MEM/WB before drainAck.
REQ-003 SHALL have parameter CNT_W, default 16, width of the stall and flush counters.
REQ-004 SHALL have ports as listed (name  direction  width  meaning):
clock  in  1  single clock, all state on rising edge.
resetN  in  1  reset, synchronous, active-low.
ID_Ex_MemRead  in  1  instruction in EX is a load.
ID_Ex_Rd  in  5  destination register of the instruction in EX.
IF_Id_Rs1  in  5  rs1 of the instruction in ID.
IF_Id_Rs2  in  5  rs2 of the instruction in ID.
IF_Id_UsesRs2  in  1  instruction in ID reads rs2.
branchTaken  in  1  taken branch/jump resolved in EX this cycle.
memBusy  in  1  data memory not ready; pipeline must freeze.
drainReq  in  1  request to stop fetch and empty the pipeline.
clearCounters  in  1  zero both counters.
PCWrite  out  1  PC register update enable.
IF_IdWrite  out  1  IF/ID register update enable.
IF_IdFlush  out  1  zero the IF/ID register.
ID_ExBubble  out  1  load control zeros into ID/EX.
pipeHold  out  1  freeze ID/EX, EX/MEM, MEM/WB.
drainAck  out  1  one-cycle pulse, pipeline empty.
stallCount  out  CNT_W  cycles with PCWrite=0, saturating.
flushCount  out  CNT_W  cycles with IF_IdFlush=1, saturating.
ctrlState  out  2  FSM state: 00 RUN, 01 FLUSH, 10 DRAIN.

Function
REQ-005 SHALL compute loadUse = ID_Ex_MemRead & (ID_Ex_Rd!=0) & ((ID_Ex_Rd==IF_Id_Rs1) | (IF_Id_UsesRs2 & ID_Ex_Rd==IF_Id_Rs2)), combinationally.
REQ-006 Control outputs SHALL be Mealy (state + current inputs), zero-cycle latency; default PCWrite=1, IF_IdWrite=1, all else 0.
REQ-007 Priority, all states: memBusy > branchTaken > drainReq (RUN only) > loadUse.
REQ-008 memBusy=1: PCWrite=0, IF_IdWrite=0, pipeHold=1, flush/bubble 0; state, flush and drain counters frozen.
REQ-009 RUN + branchTaken: PCWrite=1, IF_IdFlush=1, ID_ExBubble=1; next FLUSH with remaining=FLUSH_CYCLES-1 if FLUSH_CYCLES>1, else RUN.
REQ-010 FLUSH: IF_IdFlush=1, ID_ExBubble=1, PCWrite=1; remaining decrements; RUN after last cycle; new branchTaken reloads remaining to FLUSH_CYCLES-1.
REQ-011 RUN + drainReq: enter DRAIN, drain counter loaded DRAIN_CYCLES; this cycle PCWrite=0, IF_IdWrite=0, ID_ExBubble=1.
REQ-012 DRAIN: PCWrite=0, IF_IdWrite=0, ID_ExBubble=1; counter decrements; drainAck=1 in the cycle it reaches 1, then RUN.
REQ-013 DRAIN + branchTaken: PCWrite=1, IF_IdFlush=1 that cycle; drain counter reloads DRAIN_CYCLES; stay DRAIN.
REQ-014 RUN + loadUse only: PCWrite=0, IF_IdWrite=0, ID_ExBubble=1 for that cycle; state stays RUN.
REQ-015 loadUse SHALL be ignored in FLUSH and DRAIN.
REQ-016 stallCount +1 per cycle PCWrite=0; flushCount +1 per cycle IF_IdFlush=1; both saturate at 2^CNT_W-1, no wrap.
REQ-017 clearCounters=1 SHALL zero both counters next edge, overriding increment.

Reset
REQ-018 resetN=0 at rising edge: ctrlState=RUN, all internal counters 0, stallCount=0, flushCount=0.
REQ-019 While resetN=0: PCWrite=0, IF_IdWrite=0, IF_IdFlush=1, ID_ExBubble=1, pipeHold=0, drainAck=0; counters do not count.
REQ-020 Reset mid-FLUSH/DRAIN SHALL abort to RUN, no drainAck.

Verification
REQ-021 ID_Ex_MemRead=1, ID_Ex_Rd=5, IF_Id_Rs1=5 -> one cycle PCWrite=0, ID_ExBubble=1, stallCount=1.
REQ-022 Same but ID_Ex_Rd=0, or Rs2 match with IF_Id_UsesRs2=0 -> no stall, PCWrite=1.
REQ-023 FLUSH_CYCLES=2, branchTaken one cycle -> IF_IdFlush=1 for 2 cycles, ctrlState 00->01->00, flushCount=2.
REQ-024 drainReq in RUN, DRAIN_CYCLES=3 -> PCWrite=0 3 cycles, drainAck on 3rd, then RUN.
REQ-025 memBusy=1 for 4 cycles in FLUSH with remaining=1 -> pipeHold=1 4 cycles, then one flush cycle, RUN.
REQ-026 Force stallCount to 0xFFFF via long memBusy -> holds 0xFFFF; clearCounters -> 0.
